// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arbState_t;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port that did not own last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is taken.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic last_owner,
   output logic valid,
   output logic winner
);

   // Pick the winner; on a tie the previous owner yields.
   always_comb begin
      valid  = req_a | req_b;
      winner = OWNER_A;
      if (req_a && req_b) begin
         winner = ~last_owner;
      end else if (req_b) begin
         winner = OWNER_B;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between port A (CPU) and port B (DMA/display), one access at a time.
// Latency: gnt and mem_en one cycle after req is seen; read rvalid MEM_LAT+2 cycles after req is seen.
// Backpressure: requesters hold req and fields until gnt; a new pick is made only when the FSM is idle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // An out-of-range MEM_LAT is pulled to the nearest supported latency.
   localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                        (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
   localparam logic [1:0] LAT_LOAD = 2'(LAT - 1);

   arbState_t         state;
   arbState_t         stateNext;
   logic              lastOwner;
   logic              owner;
   logic              opWe;
   logic [ADDR_W-1:0] opAddr;
   logic [DATA_W-1:0] opWdata;
   logic [1:0]        latCnt;
   logic              pickValid;
   logic              pickWinner;

   rr_pick2 uPick (
      .req_a     (a_req),
      .req_b     (b_req),
      .last_owner(lastOwner),
      .valid     (pickValid),
      .winner    (pickWinner)
   );

   // Address and write data come straight from the latched request.
   assign mem_addr  = opAddr;
   assign mem_wdata = opWdata;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next state plus the single-cycle grant and memory strobes, all decoded from state.
   always_comb begin
      stateNext = state;
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (pickValid) begin
               stateNext = ISSUE;
            end
         end
         ISSUE: begin
            mem_en = 1'b1;
            mem_we = opWe;
            a_gnt  = (owner == OWNER_A);
            b_gnt  = (owner == OWNER_B);
            if (opWe) begin
               stateNext = IDLE;
            end else begin
               stateNext = (LAT > 1) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (latCnt == 2'd1) begin
               stateNext = RESP;
            end
         end
         RESP: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Capture the winning request, remember who owned last, and count down read latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         lastOwner <= OWNER_B;
         owner     <= OWNER_A;
         opWe      <= 1'b0;
         opAddr    <= '0;
         opWdata   <= '0;
         latCnt    <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pickValid) begin
                  owner   <= pickWinner;
                  opWe    <= (pickWinner == OWNER_A) ? a_we    : b_we;
                  opAddr  <= (pickWinner == OWNER_A) ? a_addr  : b_addr;
                  opWdata <= (pickWinner == OWNER_A) ? a_wdata : b_wdata;
               end
            end
            ISSUE: begin
               lastOwner <= owner;
               latCnt    <= LAT_LOAD;
            end
            WAIT: begin
               latCnt <= latCnt - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Return read data to the owner; the other port's rdata holds its last value.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
      end else begin
         a_rvalid <= (state == RESP) && (owner == OWNER_A);
         b_rvalid <= (state == RESP) && (owner == OWNER_B);
         if (state == RESP && owner == OWNER_A) begin
            a_rdata <= mem_rdata;
         end
         if (state == RESP && owner == OWNER_B) begin
            b_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between two requesters.
- Port A is the CPU instruction/data fetch path (outAddr, memWrite, memWriteData, memDataInbound).
- Port B is a secondary master (DMA or display fetch).
- Arbitrates round-robin, drives one memory access at a time, and returns read data with a valid pulse to the owning requester.
- Sits between the cpu top and the memory block.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  one-cycle pulse; port A request accepted this cycle.
- a_rvalid  out  1  one-cycle pulse; a_rdata valid.
- a_rdata  out  DATA_W  port A read data, registered.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A equivalents, for port B.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (sync, active-high): state=IDLE; last_owner=B; every output 0, including gnt, rvalid, rdata, mem_en, mem_we, mem_addr and mem_wdata.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No req: stay.
  - One req: that port wins.
  - Both req: the port != last_owner wins.
  - On a win: latch owner, we, addr, wdata into registers; go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the latched registers.
  - owner's gnt=1; last_owner<=owner.
  - Write: next state IDLE.
  - Read: load lat_cnt=MEM_LAT-1; next state WAIT if MEM_LAT>1, else RESP.
- WAIT: decrement lat_cnt; go to RESP when lat_cnt==1. mem_en=0.
- RESP:
  - mem_rdata is sampled into the owner's rdata register.
  - Owner's rvalid=1 on the following cycle, together with rdata.
  - FSM returns to IDLE in that same following cycle, so arbitration overlaps the rvalid cycle.
- Latency:
  - Read with MEM_LAT=1: req seen in cycle 0, gnt/mem_en in cycle 1, rvalid in cycle 3.
  - Write: gnt/mem_en in cycle 1; next grant no earlier than cycle 2 arbitration, cycle 3 issue.
- Non-owner rdata holds its last value; rvalid pulses only for reads, exactly once per granted read.
- A requester must not change its request fields between req rise and gnt. Changing them is undefined; the latched copy is what gets used.
- req still high in the cycle after gnt counts as a new request.
- Back-to-back requests from both ports strictly alternate A,B,A,B. Neither port waits more than one foreign access.
- gnt and rvalid are mutually exclusive between ports. Only one access is outstanding at a time.
- Reset mid-operation (in WAIT/RESP) drops the outstanding read: no rvalid after reset; the next tie goes to A.
- mem_en is never asserted outside ISSUE.
- Address and data are passed through unmodified; no width arithmetic.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - owner encoding OWNER_A=0, OWNER_B=1;
  - MEM_LAT legal range constants.
- One natural sub-module: rr_pick2, a combinational two-way round-robin picker (inputs: req_a, req_b, last_owner; outputs: valid, winner).
- The FSM, latency counter and response registers stay in mem_port_arbiter.

Test Plan:
- Reset, then A read addr 0x0010 (memory model holds 0xBEEF, MEM_LAT=1) -> a_gnt and mem_en in cycle 1 with mem_addr=0x0010, mem_we=0; a_rvalid in cycle 3 with a_rdata=0xBEEF; no B activity.
- A and B both read continuously from reset -> grant order A,B,A,B; each rvalid goes to the correct port with its own data.
- B write addr 0x0100 data 0x1234 -> b_gnt, mem_en=1, mem_we=1, mem_addr=0x0100, mem_wdata=0x1234 for exactly one cycle; no b_rvalid; readback via A returns 0x1234.
- MEM_LAT=3, A read -> mem_en in cycle 1, a_rvalid in cycle 5; B req raised in cycle 2 gets no gnt before cycle 5 arbitration.
- Reset asserted in WAIT of an A read -> no a_rvalid afterwards, all outputs 0; then simultaneous A/B requests -> A wins.
- No requests for 20 cycles -> mem_en, gnt and rvalid stay 0 throughout.
